alu_md: RTL and testbench
=========================

Name: alu_md

Overview:
- Successor to the single-cycle RV32I ALU, parametrised in data width (XLEN).
- Adds the RV M-extension operations: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.
- Results are registered. Multiply and divide are multi-cycle, so the block uses a valid/ready handshake on both input and output.
- Sits in the execute stage. The pipeline stalls while o_ready=0.

Parameters:
- XLEN, 32, operand/result width. Legal values: 32, 64.
- SHW, $clog2(XLEN), shift-amount width taken from i_input_b[SHW-1:0]. Derived; do not override.

Ports:
- i_clk, in, 1: clock. Everything is sampled on the rising edge.
- i_rst_n, in, 1: synchronous active-low reset.
- i_valid, in, 1: request valid.
- o_ready, out, 1: block can accept a request this cycle.
- i_input_a, in, XLEN: operand A (rs1).
- i_input_b, in, XLEN: operand B (rs2/imm).
- i_alu_op, in, 5: operation code. Codes are listed under Behaviour.
- o_valid, out, 1: result valid.
- i_ready, in, 1: consumer accepts the result.
- o_result, out, XLEN: result.
- o_zero, out, 1: o_result == 0. Combinational from the result register.

Behaviour:
- Reset (i_rst_n=0 at a clock edge):
  - state=IDLE, o_valid=0, o_result=0, o_zero=1.
  - Any divide in progress is aborted; no result is produced.
  - o_ready reads 0 during the reset cycle.
- Opcodes, bit 4 = 0 (1-cycle base ops):
  - 0_0000 ADD, 0_0001 SLL, 0_0010 SLT, 0_0011 SLTU, 0_0100 XOR, 0_0101 SRL, 0_0110 OR, 0_0111 AND, 0_1000 SUB, 0_1101 SRA.
  - Branch compares, which return 0 when the branch is taken, else 1: 0_1111 BNE, 0_1100 BLT, 0_1011 BGE, 0_1010 BLTU, 0_1001 BGEU.
  - Undefined codes return 0.
- Opcodes, bit 4 = 1 (M ops): 1_0000 MUL, 1_0001 MULH, 1_0010 MULHSU, 1_0011 MULHU, 1_0100 DIV, 1_0101 DIVU, 1_0110 REM, 1_0111 REMU. Codes 1_1xxx return 0 and take 1 cycle.
- Handshake:
  - Accept when i_valid && o_ready.
  - o_ready = (state==IDLE) && (!o_valid || i_ready).
  - Result transfers when o_valid && i_ready.
  - With o_valid=1 and i_ready=0, o_result holds stable and no new request is accepted.
- Latency (accept edge = cycle 0; o_valid rises at the edge):
  - Base ops: cycle 1. Back-to-back throughput is 1/cycle when i_ready=1.
  - MUL*: cycle 2. State MUL computes the full 2·XLEN product, with sign-extension per operand selected by the opcode. MUL returns the low half; the others return the high half.
  - DIV*/REM*: state DIV, radix-2 restoring, XLEN iterations; o_valid at cycle XLEN+1.
  - Signed divide works on magnitudes, then applies the signs: quotient negative iff the operand signs differ; remainder takes the dividend's sign.
- Divide early exit (1 cycle, no iteration):
  - Divisor = 0: quotient = all-ones, remainder = dividend.
  - Signed overflow (A = most-negative, B = -1): quotient = A, remainder = 0.
- State machine:
  - IDLE → MUL on an accepted MUL*.
  - IDLE → DIV on an accepted DIV*/REM* that is not an early-exit case.
  - MUL → IDLE after 1 cycle, loading o_result and setting o_valid.
  - DIV → IDLE when the iteration counter hits XLEN-1, loading the result.
- Operands and opcode are captured on accept; input changes after accept have no effect.
- An o_valid drop and a new accept in the same cycle are legal: the new result loads and o_valid stays 1.

Decomposition:
- Package alu_pkg holds:
  - alu_op_t, a 5-bit enum of all codes above;
  - state_t {IDLE, MUL, DIV};
  - XLEN_DEFAULT = 32.
- Sub-module div_iter holds the iterative divider. Ports: start, signed flag, a, b, busy, done, quotient, remainder. It is parametrised by XLEN and owns the counter and the early-exit logic.

Test Plan:
- ADD 0x7FFFFFFF + 1, i_ready=1 → o_result = 0x80000000 at cycle 1, o_zero = 0. Back-to-back SRA 0x80000000 >>> 31 → 0xFFFFFFFF at the next cycle.
- DIV 100 / -7 → o_ready stays 0 for cycles 1..32; o_valid at cycle 33 with result 0xFFFFFFF2 (-14). REM on the same operands → 2.
- DIVU 5 / 0 → 0xFFFFFFFF at cycle 1. REMU 5 / 0 → 5. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 at cycle 1.
- MULH 0x80000000 × 0x80000000 → 0x40000000 at cycle 2. MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF. MUL same operands → 0xFFFFFFFE.
- Backpressure: i_ready=0 for 5 cycles after an XOR result → o_result and o_valid stay stable, o_ready = 0, a new i_valid is not accepted; the transfer completes when i_ready=1.
- Reset asserted at cycle 10 of a DIVU → next cycle o_valid = 0, o_result = 0, state = IDLE. A new ADD 2 + 3 is accepted after release and yields 5.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode and state definitions for the RV32/64 IM execute-stage ALU.
package alu_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [4:0] {
        OP_ADD    = 5'b0_0000,
        OP_SLL    = 5'b0_0001,
        OP_SLT    = 5'b0_0010,
        OP_SLTU   = 5'b0_0011,
        OP_XOR    = 5'b0_0100,
        OP_SRL    = 5'b0_0101,
        OP_OR     = 5'b0_0110,
        OP_AND    = 5'b0_0111,
        OP_SUB    = 5'b0_1000,
        OP_BGEU   = 5'b0_1001,
        OP_BLTU   = 5'b0_1010,
        OP_BGE    = 5'b0_1011,
        OP_BLT    = 5'b0_1100,
        OP_SRA    = 5'b0_1101,
        OP_BNE    = 5'b0_1111,
        OP_MUL    = 5'b1_0000,
        OP_MULH   = 5'b1_0001,
        OP_MULHSU = 5'b1_0010,
        OP_MULHU  = 5'b1_0011,
        OP_DIV    = 5'b1_0100,
        OP_DIVU   = 5'b1_0101,
        OP_REM    = 5'b1_0110,
        OP_REMU   = 5'b1_0111
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV
    } state_t;

    function automatic logic is_mul(input logic [4:0] op);
        return op[4:2] == 3'b100;
    endfunction

    function automatic logic is_div(input logic [4:0] op);
        return op[4:2] == 3'b101;
    endfunction

endpackage

// File: rtl/alu_md_div_iter.sv
// Radix-2 restoring divider, one quotient bit per cycle, with
// single-cycle exits for divide-by-zero and signed overflow.
module div_iter
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic            signed_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] quotient_o,
    output logic [XLEN-1:0] remainder_o
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic            busy_q, busy_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic            qneg_q, qneg_d;
    logic            rneg_q, rneg_d;

    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN:0]   rem_sh, trial;
    logic [XLEN-1:0] rem_nx, quo_nx;

    always_comb begin
        busy_d      = busy_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        qneg_d      = qneg_q;
        rneg_d      = rneg_q;
        done_o      = 1'b0;
        quotient_o  = '0;
        remainder_o = '0;

        a_neg = signed_i & a_i[XLEN-1];
        b_neg = signed_i & b_i[XLEN-1];
        a_mag = a_neg ? -a_i : a_i;
        b_mag = b_neg ? -b_i : b_i;

        // A failed trial subtraction leaves the shifted remainder intact.
        rem_sh = {rem_q, quo_q[XLEN-1]};
        trial  = rem_sh - {1'b0, dvs_q};
        rem_nx = trial[XLEN] ? rem_sh[XLEN-1:0] : trial[XLEN-1:0];
        quo_nx = {quo_q[XLEN-2:0], ~trial[XLEN]};

        if (busy_q) begin
            rem_d = rem_nx;
            quo_d = quo_nx;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                busy_d      = 1'b0;
                done_o      = 1'b1;
                quotient_o  = qneg_q ? -quo_nx : quo_nx;
                remainder_o = rneg_q ? -rem_nx : rem_nx;
            end
        end else if (start_i) begin
            if (b_i == '0) begin
                done_o      = 1'b1;
                quotient_o  = '1;
                remainder_o = a_i;
            end else if (signed_i && a_i == MIN_NEG && b_i == '1) begin
                done_o      = 1'b1;
                quotient_o  = a_i;
                remainder_o = '0;
            end else begin
                busy_d = 1'b1;
                cnt_d  = '0;
                rem_d  = '0;
                quo_d  = a_mag;
                dvs_d  = b_mag;
                qneg_d = a_neg ^ b_neg;
                rneg_d = a_neg;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/alu_md.sv
// Execute-stage ALU with RV M-extension: registered result,
// valid/ready on both sides, multi-cycle multiply and divide.
module alu_md
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [XLEN-1:0] i_input_a,
    input  logic [XLEN-1:0] i_input_b,
    input  logic [4:0]      i_alu_op,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result,
    output logic            o_zero
);

    localparam logic [XLEN-2:0] PAD = '0;

    function automatic logic [XLEN-1:0] base_op(
        input logic [4:0]      op,
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b
    );
        logic [XLEN-1:0] r;
        logic            lt, ltu, eq;
        lt  = $signed(a) < $signed(b);
        ltu = a < b;
        eq  = a == b;
        r   = '0;
        // Branch compares return 0 when the branch is taken.
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_SLL:  r = a << b[SHW-1:0];
            OP_SRL:  r = a >> b[SHW-1:0];
            OP_SRA:  r = $unsigned($signed(a) >>> b[SHW-1:0]);
            OP_SLT:  r = {PAD, lt};
            OP_SLTU: r = {PAD, ltu};
            OP_XOR:  r = a ^ b;
            OP_OR:   r = a | b;
            OP_AND:  r = a & b;
            OP_BNE:  r = {PAD, eq};
            OP_BLT:  r = {PAD, ~lt};
            OP_BGE:  r = {PAD, lt};
            OP_BLTU: r = {PAD, ~ltu};
            OP_BGEU: r = {PAD, ltu};
            default: r = '0;
        endcase
        return r;
    endfunction

    state_t          state_q, state_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [1:0]      sub_q, sub_d;

    logic            accept;
    logic            div_start, div_busy, div_done;
    logic [XLEN-1:0] div_quo, div_rem;

    logic              sx_a, sx_b;
    logic [2*XLEN-1:0] ax, bx, prod;
    logic [XLEN-1:0]   mul_res;

    assign o_ready = i_rst_n && (state_q == IDLE) && (!valid_q || i_ready);
    assign accept  = i_valid && o_ready;

    assign div_start = accept && is_div(i_alu_op);

    div_iter #(
        .XLEN(XLEN)
    ) u_div (
        .clk_i      (i_clk),
        .rst_ni     (i_rst_n),
        .start_i    (div_start),
        .signed_i   (~i_alu_op[0]),
        .a_i        (i_input_a),
        .b_i        (i_input_b),
        .busy_o     (div_busy),
        .done_o     (div_done),
        .quotient_o (div_quo),
        .remainder_o(div_rem)
    );

    // MULH signs both operands, MULHSU only A; MUL keeps the low half.
    always_comb begin
        sx_a    = (sub_q == 2'b01) || (sub_q == 2'b10);
        sx_b    = (sub_q == 2'b01);
        ax      = {{XLEN{sx_a & a_q[XLEN-1]}}, a_q};
        bx      = {{XLEN{sx_b & b_q[XLEN-1]}}, b_q};
        prod    = ax * bx;
        mul_res = (sub_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        result_d = result_q;
        a_d      = a_q;
        b_d      = b_q;
        sub_d    = sub_q;

        if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d   = i_input_a;
                    b_d   = i_input_b;
                    sub_d = i_alu_op[1:0];
                    if (is_mul(i_alu_op)) begin
                        state_d = MUL;
                    end else if (is_div(i_alu_op)) begin
                        if (div_done) begin
                            result_d = i_alu_op[1] ? div_rem : div_quo;
                            valid_d  = 1'b1;
                        end else begin
                            state_d = DIV;
                        end
                    end else begin
                        result_d = base_op(i_alu_op, i_input_a, i_input_b);
                        valid_d  = 1'b1;
                    end
                end
            end
            MUL: begin
                result_d = mul_res;
                valid_d  = 1'b1;
                state_d  = IDLE;
            end
            DIV: begin
                if (div_done) begin
                    result_d = sub_q[1] ? div_rem : div_quo;
                    valid_d  = 1'b1;
                    state_d  = IDLE;
                end else if (!div_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            valid_q  <= 1'b0;
            result_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= '0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            result_q <= result_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sub_q    <= sub_d;
        end
    end

    assign o_valid  = valid_q;
    assign o_result = result_q;
    assign o_zero   = (result_q == '0);

endmodule

// File: tb/tb_alu_md.sv
// Self-checking bench for alu_md: directed scenarios plus random ops
// checked against a plain-arithmetic reference model.
module tb_alu_md;

    localparam logic [31:0] MINN = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_ready = 1'b1;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [4:0]  op = '0;
    logic        o_ready, o_valid, o_zero;
    logic [31:0] o_result;

    int n_checks = 0;
    int n_err = 0;

    alu_md #(.XLEN(32)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_input_a(in_a),
        .i_input_b(in_b),
        .i_alu_op (op),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_result (o_result),
        .o_zero   (o_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [31:0] ref_res(input logic [4:0] o,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        int sa, sb;
        longint p;
        logic [63:0] u;
        logic ovf;
        sa = a;
        sb = b;
        ovf = (a == MINN) && (b == 32'hFFFF_FFFF);
        case (o)
            5'd0:  return a + b;
            5'd1:  return a << b[4:0];
            5'd2:  return 32'(sa < sb);
            5'd3:  return 32'(a < b);
            5'd4:  return a ^ b;
            5'd5:  return a >> b[4:0];
            5'd6:  return a | b;
            5'd7:  return a & b;
            5'd8:  return a - b;
            5'd9:  return 32'(a < b);
            5'd10: return 32'(a >= b);
            5'd11: return 32'(sa < sb);
            5'd12: return 32'(sa >= sb);
            5'd13: return 32'(sa >>> b[4:0]);
            5'd15: return 32'(a == b);
            5'd16: return a * b;
            5'd17: begin
                p = longint'(sa) * longint'(sb);
                return p[63:32];
            end
            5'd18: begin
                p = longint'(sa) * longint'({32'd0, b});
                return p[63:32];
            end
            5'd19: begin
                u = {32'd0, a} * {32'd0, b};
                return u[63:32];
            end
            5'd20: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                return sa / sb;
            end
            5'd21: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            5'd22: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                return sa % sb;
            end
            5'd23: return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    // Clock edges between accept and the result appearing.
    function automatic int ref_lat(input logic [4:0] o,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        if (!o[4] || o[3]) return 0;
        if (!o[2]) return 1;
        if (b == 0) return 0;
        if (!o[0] && a == MINN && b == 32'hFFFF_FFFF) return 0;
        return 32;
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return MINN;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    task automatic issue(input logic [4:0] o, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] r,
                         output logic z, output int lat,
                         output bit stalled);
        int guard;
        @(negedge clk);
        i_valid = 1'b1;
        op = o;
        in_a = a;
        in_b = b;
        guard = 0;
        while (!o_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        in_a = $urandom;
        in_b = $urandom;
        op = 5'($urandom);
        lat = 0;
        stalled = 1'b1;
        @(negedge clk);
        while (!o_valid && lat < 100) begin
            if (o_ready) stalled = 1'b0;
            @(negedge clk);
            lat++;
        end
        r = o_result;
        z = o_zero;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (o_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_valid: got %b want 0", o_valid);
        end
        n_checks++;
        if (o_result !== 32'd0) begin
            n_err++;
            $display("FAIL reset_result: got %h want 0", o_result);
        end
        n_checks++;
        if (o_zero !== 1'b1) begin
            n_err++;
            $display("FAIL reset_zero: got %b want 1", o_zero);
        end
        n_checks++;
        if (o_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ready: got %b want 0", o_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (o_ready !== 1'b1) begin
            n_err++;
            $display("FAIL post_reset_ready: got %b want 1", o_ready);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        i_valid = 1'b1;
        op = 5'd0;
        in_a = 32'h7FFF_FFFF;
        in_b = 32'd1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (o_valid !== 1'b1 || o_result !== 32'h8000_0000) begin
            n_err++;
            $display("FAIL add_ovf: got v=%b %h want v=1 80000000",
                     o_valid, o_result);
        end
        n_checks++;
        if (o_zero !== 1'b0) begin
            n_err++;
            $display("FAIL add_zero: got %b want 0", o_zero);
        end
        op = 5'd13;
        in_a = 32'h8000_0000;
        in_b = 32'd31;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (o_valid !== 1'b1 || o_result !== 32'hFFFF_FFFF) begin
            n_err++;
            $display("FAIL sra_b2b: got v=%b %h want v=1 ffffffff",
                     o_valid, o_result);
        end
        i_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (o_valid !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_drain: got v=%b want 0", o_valid);
        end
    endtask

    task automatic test_div();
        logic [31:0] r;
        logic z;
        int lat;
        bit st;
        issue(5'd20, 32'd100, -32'd7, r, z, lat, st);
        n_checks++;
        if (r !== 32'hFFFF_FFF2 || lat != 32) begin
            n_err++;
            $display("FAIL div_100_m7: got %h lat %0d want fffffff2 lat 32",
                     r, lat);
        end
        n_checks++;
        if (!st) begin
            n_err++;
            $display("FAIL div_stall: o_ready got 1 during divide want 0");
        end
        issue(5'd22, 32'd100, -32'd7, r, z, lat, st);
        n_checks++;
        if (r !== 32'd2 || lat != 32) begin
            n_err++;
            $display("FAIL rem_100_m7: got %h lat %0d want 2 lat 32", r, lat);
        end
    endtask

    task automatic test_div_edge();
        logic [31:0] r;
        logic z;
        int lat;
        bit st;
        issue(5'd21, 32'd5, 32'd0, r, z, lat, st);
        n_checks++;
        if (r !== 32'hFFFF_FFFF || lat != 0) begin
            n_err++;
            $display("FAIL divu_by0: got %h lat %0d want ffffffff lat 0",
                     r, lat);
        end
        issue(5'd23, 32'd5, 32'd0, r, z, lat, st);
        n_checks++;
        if (r !== 32'd5 || lat != 0) begin
            n_err++;
            $display("FAIL remu_by0: got %h lat %0d want 5 lat 0", r, lat);
        end
        issue(5'd20, MINN, 32'hFFFF_FFFF, r, z, lat, st);
        n_checks++;
        if (r !== MINN || lat != 0) begin
            n_err++;
            $display("FAIL div_ovf: got %h lat %0d want 80000000 lat 0",
                     r, lat);
        end
        issue(5'd22, MINN, 32'hFFFF_FFFF, r, z, lat, st);
        n_checks++;
        if (r !== 32'd0 || z !== 1'b1) begin
            n_err++;
            $display("FAIL rem_ovf: got %h z=%b want 0 z=1", r, z);
        end
    endtask

    task automatic test_mul();
        logic [31:0] r;
        logic z;
        int lat;
        bit st;
        issue(5'd17, MINN, MINN, r, z, lat, st);
        n_checks++;
        if (r !== 32'h4000_0000 || lat != 1 || !st) begin
            n_err++;
            $display("FAIL mulh_min: got %h lat %0d st %b want 40000000 1 1",
                     r, lat, st);
        end
        issue(5'd18, 32'hFFFF_FFFF, 32'd2, r, z, lat, st);
        n_checks++;
        if (r !== 32'hFFFF_FFFF || lat != 1) begin
            n_err++;
            $display("FAIL mulhsu: got %h lat %0d want ffffffff lat 1",
                     r, lat);
        end
        issue(5'd16, 32'hFFFF_FFFF, 32'd2, r, z, lat, st);
        n_checks++;
        if (r !== 32'hFFFF_FFFE || lat != 1) begin
            n_err++;
            $display("FAIL mul_lo: got %h lat %0d want fffffffe lat 1",
                     r, lat);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp;
        exp = 32'hF0F0_1234 ^ 32'h0FF0_4321;
        @(negedge clk);
        i_ready = 1'b0;
        i_valid = 1'b1;
        op = 5'd4;
        in_a = 32'hF0F0_1234;
        in_b = 32'h0FF0_4321;
        @(posedge clk);
        @(negedge clk);
        op = 5'd0;
        in_a = 32'd2;
        in_b = 32'd3;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (o_valid !== 1'b1 || o_result !== exp || o_ready !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold%0d: got v=%b r=%h rdy=%b want 1 %h 0",
                         i, o_valid, o_result, o_ready, exp);
            end
            @(negedge clk);
        end
        i_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (o_valid !== 1'b1 || o_result !== 32'd5) begin
            n_err++;
            $display("FAIL bp_release: got v=%b %h want v=1 5",
                     o_valid, o_result);
        end
        i_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (o_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_drain: got v=%b want 0", o_valid);
        end
    endtask

    task automatic test_reset_mid_div();
        logic [31:0] r;
        logic z;
        int lat;
        bit st, seen;
        @(negedge clk);
        i_valid = 1'b1;
        op = 5'd21;
        in_a = 32'd1000;
        in_b = 32'd3;
        @(posedge clk);
        #1 i_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (o_valid !== 1'b0 || o_result !== 32'd0 || o_zero !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_div: got v=%b r=%h z=%b want 0 0 1",
                     o_valid, o_result, o_zero);
        end
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (o_valid) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin
            n_err++;
            $display("FAIL rst_abort: got stray result want none");
        end
        issue(5'd0, 32'd2, 32'd3, r, z, lat, st);
        n_checks++;
        if (r !== 32'd5 || lat != 0) begin
            n_err++;
            $display("FAIL rst_add: got %h lat %0d want 5 lat 0", r, lat);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, r, exp;
        logic [4:0] o;
        logic z;
        int lat, elat;
        bit st;
        for (int i = 0; i < 300; i++) begin
            o = 5'($urandom_range(0, 31));
            a = rnd_operand();
            b = rnd_operand();
            exp = ref_res(o, a, b);
            elat = ref_lat(o, a, b);
            issue(o, a, b, r, z, lat, st);
            n_checks++;
            if (r !== exp) begin
                n_err++;
                $display("FAIL rnd_res op=%0d a=%h b=%h: got %h want %h",
                         o, a, b, r, exp);
            end
            n_checks++;
            if (lat != elat) begin
                n_err++;
                $display("FAIL rnd_lat op=%0d a=%h b=%h: got %0d want %0d",
                         o, a, b, lat, elat);
            end
            n_checks++;
            if (z !== (exp == 32'd0)) begin
                n_err++;
                $display("FAIL rnd_zero op=%0d: got %b want %b",
                         o, z, exp == 32'd0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_div();
        test_div_edge();
        test_mul();
        test_backpressure();
        test_reset_mid_div();
        test_random();
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule
